// File: rtl/pc_unit_if.sv
// Bundle of the pc_unit control inputs and fetch-address outputs.
// master drives stall/branch/resume; slave is the pc_unit itself.
interface pc_unit_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             resume;
    logic [XLEN-1:0]  pc_out;
    logic             fetch_valid;
    logic             halted;
    logic             fault_misaligned;
    logic             fault_oob;
    logic [CNT_W-1:0] advance_count;

    modport master (
        output stall, branch_taken, branch_target, resume,
        input  pc_out, fetch_valid, halted, fault_misaligned, fault_oob, advance_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, resume,
        output pc_out, fetch_valid, halted, fault_misaligned, fault_oob, advance_count
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: registers the next fetch address with stall, redirect,
// alignment / range checking, a HOLD/RUN/HALT state machine and an advance counter.
module pc_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter longint unsigned IMEM_BYTES   = 16,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     OOB_MODE     = 0,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic      clk,
    input  logic      reset,
    pc_unit_if.slave  bus
);
    typedef enum logic [1:0] {HOLD, RUN, HALT} state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
    localparam logic [XLEN:0]   STEP       = (XLEN+1)'(INSTR_BYTES);

    state_t           state, state_nxt;
    logic [XLEN-1:0]  pc, pc_nxt;
    logic             fm, fm_nxt;
    logic             fo, fo_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

    logic [XLEN:0]    seq_sum;
    logic [XLEN-1:0]  cand;
    logic             misaligned;
    logic             oob;

    always_comb begin
        seq_sum    = {1'b0, pc} + STEP;
        cand       = bus.branch_taken ? bus.branch_target : seq_sum[XLEN-1:0];
        misaligned = (cand & ALIGN_MASK) != '0;
        // a carry out of the sequential increment is treated as out of range
        oob        = (!bus.branch_taken && seq_sum[XLEN]) || (cand >= IMEM_LIMIT);
        cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        fm_nxt    = fm;
        cnt_nxt   = cnt;
        // wrap-mode fault_oob is a pulse: it drops on the edge after the wrap
        fo_nxt    = (OOB_MODE == 0) ? 1'b0 : fo;

        case (state)
            HOLD: state_nxt = RUN;
            RUN: begin
                if (!bus.stall) begin
                    if (misaligned) begin
                        state_nxt = HALT;
                        fm_nxt    = 1'b1;
                    end else if (oob) begin
                        if (OOB_MODE == 0) begin
                            pc_nxt  = RESET_VECTOR;
                            fo_nxt  = 1'b1;
                            cnt_nxt = cnt_inc;
                        end else begin
                            state_nxt = HALT;
                            fo_nxt    = 1'b1;
                        end
                    end else begin
                        pc_nxt  = cand;
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_nxt = RUN;
                    pc_nxt    = RESET_VECTOR;
                    fm_nxt    = 1'b0;
                    fo_nxt    = 1'b0;
                end
            end
            default: state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HOLD;
            pc    <= RESET_VECTOR;
            fm    <= 1'b0;
            fo    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            fm    <= fm_nxt;
            fo    <= fo_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.pc_out           = pc;
    assign bus.fetch_valid      = (state == RUN);
    assign bus.halted           = (state == HALT);
    assign bus.fault_misaligned = fm;
    assign bus.fault_oob        = fo;
    assign bus.advance_count    = cnt;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: wrap-mode, halt-mode and 3-bit-counter instances
// checked through a scoreboard of expected output snapshots.
module tb_pc_unit;
    logic clk;
    logic reset;

    pc_unit_if #(.XLEN(64), .CNT_W(32)) bus0 ();
    pc_unit_if #(.XLEN(64), .CNT_W(32)) bus1 ();
    pc_unit_if #(.XLEN(64), .CNT_W(3))  bus2 ();

    pc_unit #(.XLEN(64), .OOB_MODE(0), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pc_unit #(.XLEN(64), .OOB_MODE(1), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pc_unit #(.XLEN(64), .OOB_MODE(0), .CNT_W(3))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned dut;
        string       tag;
        logic [63:0] pc;
        logic        fv;
        logic        hl;
        logic        fm;
        logic        fo;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned fails  = 0;

    // reference model of the 3-bit-counter instance, which runs free
    logic        m2_run;
    logic [63:0] m2_pc;
    logic        m2_fo;
    logic [31:0] m2_cnt;

    task automatic expect_state(input int unsigned dut, input string tag, input logic [63:0] pc,
                                input logic fv, input logic hl, input logic fm, input logic fo,
                                input logic [31:0] cnt);
        exp_t e;
        e.dut = dut; e.tag = tag; e.pc = pc; e.fv = fv; e.hl = hl;
        e.fm = fm; e.fo = fo; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        logic [63:0] o_pc;
        logic        o_fv, o_hl, o_fm, o_fo;
        logic [31:0] o_cnt;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0: begin
                    o_pc = bus0.pc_out; o_fv = bus0.fetch_valid; o_hl = bus0.halted;
                    o_fm = bus0.fault_misaligned; o_fo = bus0.fault_oob; o_cnt = bus0.advance_count;
                end
                1: begin
                    o_pc = bus1.pc_out; o_fv = bus1.fetch_valid; o_hl = bus1.halted;
                    o_fm = bus1.fault_misaligned; o_fo = bus1.fault_oob; o_cnt = bus1.advance_count;
                end
                default: begin
                    o_pc = bus2.pc_out; o_fv = bus2.fetch_valid; o_hl = bus2.halted;
                    o_fm = bus2.fault_misaligned; o_fo = bus2.fault_oob;
                    o_cnt = 32'(bus2.advance_count);
                end
            endcase
            cmp($sformatf("d%0d.%s.pc", e.dut, e.tag), o_pc, e.pc);
            cmp($sformatf("d%0d.%s.fetch_valid", e.dut, e.tag), 64'(o_fv), 64'(e.fv));
            cmp($sformatf("d%0d.%s.halted", e.dut, e.tag), 64'(o_hl), 64'(e.hl));
            cmp($sformatf("d%0d.%s.fault_misaligned", e.dut, e.tag), 64'(o_fm), 64'(e.fm));
            cmp($sformatf("d%0d.%s.fault_oob", e.dut, e.tag), 64'(o_fo), 64'(e.fo));
            cmp($sformatf("d%0d.%s.count", e.dut, e.tag), 64'(o_cnt), 64'(e.cnt));
        end
    endtask

    task automatic m2_reset();
        m2_run = 1'b0; m2_pc = '0; m2_fo = 1'b0; m2_cnt = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            m2_reset();
        end else if (!m2_run) begin
            m2_run = 1'b1;
        end else begin
            m2_fo = 1'b0;
            if (m2_pc + 64'd4 >= 64'd16) begin
                m2_pc = '0;
                m2_fo = 1'b1;
            end else begin
                m2_pc = m2_pc + 64'd4;
            end
            if (m2_cnt < 32'd7) m2_cnt = m2_cnt + 32'd1;
        end
        expect_state(2, "free", m2_pc, m2_run, 1'b0, 1'b0, m2_fo, m2_cnt);
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m2_reset();
        reset = 1'b1;
        bus0.stall = 1'b0; bus0.branch_taken = 1'b0; bus0.branch_target = '0; bus0.resume = 1'b0;
        bus1.stall = 1'b0; bus1.branch_taken = 1'b0; bus1.branch_target = '0; bus1.resume = 1'b0;
        bus2.stall = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_target = '0; bus2.resume = 1'b0;

        // reset state
        expect_state(0, "rst", 64'd0, 0, 0, 0, 0, 0);
        expect_state(1, "rst", 64'd0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;

        // HOLD -> RUN, first fetch at the reset vector
        expect_state(0, "first", 64'd0, 1, 0, 0, 0, 0);
        expect_state(1, "first", 64'd0, 1, 0, 0, 0, 0);
        step();
        for (int i = 1; i <= 3; i++) begin
            expect_state(0, "seq", 64'(4 * i), 1, 0, 0, 0, 32'(i));
            expect_state(1, "seq", 64'(4 * i), 1, 0, 0, 0, 32'(i));
            step();
        end
        // 12 + 4 is out of range: wrap with pulse vs. halt
        expect_state(0, "wrap", 64'd0, 1, 0, 0, 1, 4);
        expect_state(1, "oobhalt", 64'd12, 0, 1, 0, 1, 3);
        step();
        expect_state(0, "afterwrap", 64'd4, 1, 0, 0, 0, 5);
        expect_state(1, "oobhold", 64'd12, 0, 1, 0, 1, 3);
        step();

        // stall beats branch; halted instance ignores stall/branch
        bus0.stall = 1'b1; bus0.branch_taken = 1'b1; bus0.branch_target = 64'd12;
        bus1.stall = 1'b1; bus1.branch_taken = 1'b1; bus1.branch_target = 64'd4;
        for (int i = 0; i < 2; i++) begin
            expect_state(0, "stall", 64'd4, 1, 0, 0, 0, 5);
            expect_state(1, "haltign", 64'd12, 0, 1, 0, 1, 3);
            step();
        end
        bus0.stall = 1'b0;
        bus1.stall = 1'b0;
        expect_state(0, "branch", 64'd12, 1, 0, 0, 0, 6);
        expect_state(1, "haltign2", 64'd12, 0, 1, 0, 1, 3);
        step();

        // misaligned redirect
        bus0.branch_target = 64'd6;
        expect_state(0, "misalign", 64'd12, 0, 1, 1, 0, 6);
        step();

        // resume from HALT on both halted instances
        bus0.branch_taken = 1'b0; bus0.resume = 1'b1;
        bus1.branch_taken = 1'b0; bus1.resume = 1'b1;
        expect_state(0, "resume", 64'd0, 1, 0, 0, 0, 6);
        expect_state(1, "resume", 64'd0, 1, 0, 0, 0, 3);
        step();
        // resume held in RUN has no effect
        expect_state(0, "resumerun", 64'd4, 1, 0, 0, 0, 7);
        expect_state(1, "resumerun", 64'd4, 1, 0, 0, 0, 4);
        step();
        bus0.resume = 1'b0;
        bus1.resume = 1'b0;
        expect_state(0, "pc8", 64'd8, 1, 0, 0, 0, 8);
        expect_state(1, "pc8", 64'd8, 1, 0, 0, 0, 5);
        step();

        // asynchronous reset between edges
        #3;
        reset = 1'b1;
        m2_reset();
        expect_state(0, "asyncrst", 64'd0, 0, 0, 0, 0, 0);
        expect_state(1, "asyncrst", 64'd0, 0, 0, 0, 0, 0);
        expect_state(2, "asyncrst", 64'd0, 0, 0, 0, 0, 0);
        #1;
        drain();
        #1;
        reset = 1'b0;
        expect_state(0, "rerun", 64'd0, 1, 0, 0, 0, 0);
        step();
        expect_state(0, "rerun2", 64'd4, 1, 0, 0, 0, 1);
        step();

        // saturation of the 3-bit counter after more than 10 advances
        for (int i = 0; i < 10; i++) step();
        expect_state(2, "sat", m2_pc, 1, 0, 0, m2_fo, 32'd7);
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
